// File: rtl/inst_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_if
// Bundles the instruction-memory request/response signals and the cpu-side
// delivery handshake of the fetch front-end.
//
//   im_data        memory -> fetch  instruction word, valid the cycle after a read
//   inst_mem_read  fetch -> memory  read strobe
//   im_address     fetch -> memory  byte address of the read
//   inst_out       fetch -> cpu     head-of-queue instruction
//   inst_pc        fetch -> cpu     PC of inst_out
//   inst_valid     fetch -> cpu     queue holds at least one word
//   inst_ready     cpu -> fetch     cpu takes the head this cycle
//   redirect       cpu -> fetch     flush everything and restart at redirect_pc
//   redirect_pc    cpu -> fetch     new fetch address
//
// Modports: master = the fetch queue itself, slave = memory + cpu side.
// -----------------------------------------------------------------------------
interface inst_fetch_queue_if #(
    parameter int MACHINE_WIDTH = 32
);
    logic [MACHINE_WIDTH-1:0] im_data;
    logic                     inst_mem_read;
    logic [MACHINE_WIDTH-1:0] im_address;
    logic [MACHINE_WIDTH-1:0] inst_out;
    logic [MACHINE_WIDTH-1:0] inst_pc;
    logic                     inst_valid;
    logic                     inst_ready;
    logic                     redirect;
    logic [MACHINE_WIDTH-1:0] redirect_pc;

    modport master (
        input  im_data,
        input  inst_ready,
        input  redirect,
        input  redirect_pc,
        output inst_mem_read,
        output im_address,
        output inst_out,
        output inst_pc,
        output inst_valid
    );

    modport slave (
        output im_data,
        output inst_ready,
        output redirect,
        output redirect_pc,
        input  inst_mem_read,
        input  im_address,
        input  inst_out,
        input  inst_pc,
        input  inst_valid
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
// Instruction fetch front-end. Issues sequential word reads to a synchronous
// instruction memory, buffers returned words together with their PCs in a
// small FIFO and hands them to the cpu over a valid/ready handshake. A
// redirect flushes buffered and in-flight words and restarts fetching.
//
// Ports:
//   clk           clock, all state on the rising edge
//   reset         asynchronous active-low reset (0 = in reset)
//   bus           inst_fetch_queue_if.master (memory + cpu signals)
//   stat_fetches  (IFQ_STATS_EN only) count of read-strobe cycles, wraps
//   stat_flushes  (IFQ_STATS_EN only) count of redirect cycles, wraps
//
// Optional feature macro: IFQ_STATS_EN adds the two statistics counters.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int                       MACHINE_WIDTH = 32,
    parameter int                       QUEUE_DEPTH   = 4,
    parameter logic [MACHINE_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    inst_fetch_queue_if.master       bus
`ifdef IFQ_STATS_EN
    ,
    output logic [MACHINE_WIDTH-1:0] stat_fetches,
    output logic [MACHINE_WIDTH-1:0] stat_flushes
`endif
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(QUEUE_DEPTH);

    logic [MACHINE_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [MACHINE_WIDTH-1:0] tag_q, tag_d;
    logic [CW-1:0]            count_q, count_d;
    logic [PW-1:0]            head_q, head_d;
    logic [PW-1:0]            tail_q, tail_d;
    logic                     inflight_q, inflight_d;
    logic                     drop_q, drop_d;

    logic [MACHINE_WIDTH-1:0] entry_data [QUEUE_DEPTH];
    logic [MACHINE_WIDTH-1:0] entry_pc   [QUEUE_DEPTH];

    logic credit_ok;
    logic issue;
    logic queue_valid;
    logic push;
    logic pop;

    // Credits count both stored words and the one possibly in flight, so an
    // issued read always has a free slot when its word comes back.
    assign credit_ok   = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < DEPTH_C;
    // Gating with reset keeps the strobe low while reset is held, even
    // though the cleared credit state would otherwise allow a read.
    assign issue       = reset & ~bus.redirect & credit_ok;
    assign queue_valid = (count_q != '0);
    // A response arriving during a redirect belongs to the old stream.
    assign push        = inflight_q & ~drop_q & ~bus.redirect;
    assign pop         = queue_valid & bus.inst_ready & ~bus.redirect;

    assign bus.inst_mem_read = issue;
    assign bus.im_address    = fetch_pc_q;
    assign bus.inst_valid    = queue_valid;
    assign bus.inst_out      = queue_valid ? entry_data[head_q] : '0;
    assign bus.inst_pc       = queue_valid ? entry_pc[head_q]   : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tag_d      = tag_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = 1'b0;
        drop_d     = 1'b0;

        if (bus.redirect) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = bus.redirect_pc & ~MACHINE_WIDTH'(3);
            drop_d     = inflight_q;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + MACHINE_WIDTH'(4);
                tag_d      = fetch_pc_q;
                inflight_d = 1'b1;
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            tag_q      <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_q      <= tag_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Storage needs no reset: outputs are forced to zero while empty and an
    // entry is only read after it has been written.
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
        logic [MACHINE_WIDTH-1:0] data_q;
        logic [MACHINE_WIDTH-1:0] pc_q;

        always_ff @(posedge clk) begin
            if (push && (tail_q == PW'(gi))) begin
                data_q <= bus.im_data;
                pc_q   <= tag_q;
            end
        end

        assign entry_data[gi] = data_q;
        assign entry_pc[gi]   = pc_q;
    end

`ifdef IFQ_STATS_EN
    logic [MACHINE_WIDTH-1:0] stat_fetches_q;
    logic [MACHINE_WIDTH-1:0] stat_flushes_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_fetches_q <= '0;
            stat_flushes_q <= '0;
        end else begin
            if (issue) begin
                stat_fetches_q <= stat_fetches_q + MACHINE_WIDTH'(1);
            end
            if (bus.redirect) begin
                stat_flushes_q <= stat_flushes_q + MACHINE_WIDTH'(1);
            end
        end
    end

    assign stat_fetches = stat_fetches_q;
    assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Instruction fetch front-end between the instruction memory and the cpu core. Generates sequential fetch addresses, issues reads to the synchronous instruction memory, and buffers returned words with their PCs in a small FIFO. Delivers them to the cpu over a valid/ready handshake. Supports redirect (branch/jump), which flushes buffered and in-flight fetches.

Parameters:
MACHINE_WIDTH, 32, data/address width in bits
QUEUE_DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 0, fetch address after reset (word aligned)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 = reset asserted
im_data  input  MACHINE_WIDTH  instruction word from memory, valid the cycle after inst_mem_read=1
inst_mem_read  output  1  read strobe to instruction memory
im_address  output  MACHINE_WIDTH  byte address to instruction memory
inst_out  output  MACHINE_WIDTH  head-of-queue instruction
inst_pc  output  MACHINE_WIDTH  PC of inst_out
inst_valid  output  1  queue non-empty
inst_ready  input  1  cpu accepts head this cycle
redirect  input  1  discard all fetched/in-flight words, restart at redirect_pc
redirect_pc  input  MACHINE_WIDTH  new fetch address

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC, count=0, head/tail ptrs=0, inflight=0, drop=0; outputs: inst_mem_read=0, im_address=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0.
- im_address = fetch_pc, combinational. inst_mem_read=1 iff !redirect and (count + inflight) < QUEUE_DEPTH. Credit check uses registered values only, so the queue never overflows.
- On issue: fetch_pc <= fetch_pc+4, modulo 2^MACHINE_WIDTH (wraps silently). inflight <= 1 and tag <= fetch_pc; otherwise inflight <= 0.
- Response: in the cycle after an issue, with inflight=1 and drop=0, im_data and tag are written at tail on that cycle's edge.
- Latency: a read issued in cycle N gives inst_valid=1 with that word in cycle N+2. Steady state is 1 instr/cycle with inst_ready held high.
- Pop: inst_valid && inst_ready advances head on the edge. Push and pop in the same cycle leave count unchanged.
- inst_out/inst_pc are driven from the head entry. They hold stable while inst_valid=1 and inst_ready=0. They read 0 when the queue is empty.
- Redirect (highest priority): count <= 0, ptrs reset, and any pop is ignored. fetch_pc <= {redirect_pc[MSB:2],2'b00}; low two bits are always cleared. inst_mem_read=0 in the redirect cycle. drop <= inflight, so a response arriving next cycle is discarded; drop clears after one cycle.
- The first post-redirect read issues in cycle R+1; its word is valid in R+3.
- Redirect held for several cycles: fetching stays stalled, and the last cycle's redirect_pc wins.
- Reset asserted mid-operation: state clears immediately, independent of clk. The in-flight response is not captured.

Optional Feature:
IFQ_STATS_EN. When defined, add output ports stat_fetches (MACHINE_WIDTH) and stat_flushes (MACHINE_WIDTH), both reset to 0.
- stat_fetches increments on every inst_mem_read=1 cycle.
- stat_flushes increments on every redirect=1 cycle.
- Both counters wrap.
When undefined, neither port nor the counter logic exists, and all other behaviour is identical.

Test Plan:
1. Release reset, inst_ready=1, memory word = address → reads at 0x0,0x4,0x8,...; inst_valid rises 2 cycles after first read; inst_pc/inst_out = 0x0,0x4,0x8 on consecutive cycles.
2. inst_ready=0 from reset → exactly 4 reads (0x0–0xC), then inst_mem_read=0; inst_out holds 0x0. Raise inst_ready → 0x0,0x4,0x8,0xC in order, then fetch resumes at 0x10.
3. redirect=1, redirect_pc=0x100 while read of 0x10 is in flight → 0x10 never appears; next inst_pc=0x100 in R+3, then 0x104.
4. redirect_pc=0x103 → im_address=0x100 in R+1; delivered inst_pc=0x100.
5. RESET_PC=0xFFFFFFF8, inst_ready=1 → inst_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
6. Reset pulled low mid-stream with queue holding 3 entries → inst_valid=0 and inst_mem_read=0 without a clock edge. After release, fetching restarts at RESET_PC. With IFQ_STATS_EN, counters read 0.
